// File: rtl/dds_chirp_pkg.sv
// +----------------------------------------------------------------------+
// | dds_chirp_pkg: shared encodings and helpers for the chirp DDS        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package dds_chirp_pkg;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_TRI  = 2'b10;
  localparam logic [1:0] MODE_CW   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PIPE_LAT = 3;

  function automatic int mid_scale(input int dac_bits);
    return 1 << (dac_bits - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dds_sin_lut.sv
// +----------------------------------------------------------------------+
// | dds_sin_lut: quarter-wave sine magnitude ROM with one registered read|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module dds_sin_lut #(
  parameter int ADDR_BITS = 8,
  parameter int MAG_BITS  = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] i_addr,
  output logic [MAG_BITS-1:0]  o_mag
);

  localparam int c_depth = 1 << ADDR_BITS;

  // round((2^MAG_BITS-1) * sin(idx*pi/(2*depth))), Taylor series in Q30
  function automatic logic [MAG_BITS-1:0] sin_mag(input int idx);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint den;
    x    = (longint'(idx) * 64'sd1686629713) >>> ADDR_BITS;
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (longint k = 1; k <= 7; k++) begin
      den  = (k + k) * (k + k + 64'sd1);
      term = -(((term * x2) >>> 30) / den);
      sum  = sum + term;
    end
    return MAG_BITS'((sum * ((64'sd1 <<< MAG_BITS) - 64'sd1) + (64'sd1 <<< 29)) >>> 30);
  endfunction

  logic [MAG_BITS-1:0] w_rom [c_depth];

  for (genvar gi = 0; gi < c_depth; gi++) begin : g_rom
    localparam logic [MAG_BITS-1:0] c_val = sin_mag(gi);
    assign w_rom[gi] = c_val;
  end

  logic [MAG_BITS-1:0] r_mag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_mag <= '0;
    else      r_mag <= w_rom[i_addr];
  end

  assign o_mag = r_mag;

endmodule

`default_nettype wire

// File: rtl/dds_chirp_gen.sv
// +----------------------------------------------------------------------+
// | dds_chirp_gen: programmable linear-FM DDS with sweep control and     |
// | valid-qualified offset-binary DAC stream. Optional phase dither is   |
// | enabled by defining DDS_CHIRP_DITHER_EN.                              |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module dds_chirp_gen
  import dds_chirp_pkg::*;
#(
  parameter int DAC_BITS   = 12,
  parameter int PHASE_BITS = 32,
  parameter int FRAC_BITS  = 32,
  parameter int LUT_BITS   = 10,
  parameter int CNT_BITS   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [1:0]                    mode,
  input  logic [PHASE_BITS-1:0]         f_start,
  input  logic [PHASE_BITS+FRAC_BITS-1:0] f_step,
  input  logic [CNT_BITS-1:0]           sweep_len,
  input  logic [CNT_BITS-1:0]           n_sweeps,
  output logic                          busy,
  output logic                          done,
  output logic                          sweep_sync,
  output logic                          dac_valid,
  output logic [DAC_BITS-1:0]           dac_data
);

  localparam int c_acc_bits  = PHASE_BITS + FRAC_BITS;
  localparam int c_addr_bits = LUT_BITS - 2;
  localparam int c_mag_bits  = DAC_BITS - 1;
  localparam logic [DAC_BITS-1:0]   c_mid  = DAC_BITS'(mid_scale(DAC_BITS));
  localparam logic [c_mag_bits-1:0] c_full = '1;

  state_t r_state, w_state_nxt;

  logic [1:0]            r_mode;
  logic [PHASE_BITS-1:0] r_f_start;
  logic [c_acc_bits-1:0] r_f_step;
  logic [CNT_BITS-1:0]   r_len_last, r_n_sweeps, r_len_cnt, r_sweep_cnt;
  logic                  r_dir_down;
  logic [PHASE_BITS-1:0] r_phase;
  logic [c_acc_bits-1:0] r_freq;

  logic w_accept, w_run, w_ramp_end, w_last;

  assign w_run      = (r_state == RUN);
  assign w_accept   = (r_state == IDLE) && start && !abort;
  assign w_ramp_end = (r_len_cnt == r_len_last);
  assign w_last     = w_ramp_end && (r_n_sweeps != '0) &&
                      ((r_sweep_cnt + CNT_BITS'(1)) == r_n_sweeps);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != IDLE);
    done        = (r_state == DONE);
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (abort) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode      <= MODE_UP;
      r_f_start   <= '0;
      r_f_step    <= '0;
      r_len_last  <= '0;
      r_n_sweeps  <= '0;
      r_len_cnt   <= '0;
      r_sweep_cnt <= '0;
      r_dir_down  <= 1'b0;
      r_phase     <= '0;
      r_freq      <= '0;
    end else if (w_accept) begin
      r_mode      <= mode;
      r_f_start   <= f_start;
      r_f_step    <= f_step;
      r_len_last  <= (sweep_len == '0) ? '0 : sweep_len - CNT_BITS'(1);
      r_n_sweeps  <= n_sweeps;
      r_len_cnt   <= '0;
      r_sweep_cnt <= '0;
      r_dir_down  <= (mode == MODE_DOWN);
      r_phase     <= '0;
      r_freq      <= {f_start, {FRAC_BITS{1'b0}}};
    end else if (w_run) begin
      r_phase <= r_phase + r_freq[c_acc_bits-1 -: PHASE_BITS];
      if (r_mode != MODE_CW) begin
        // UP/DOWN restart from f_start; TRIANGLE keeps ramping and only turns around
        if (w_ramp_end && (r_mode != MODE_TRI))
          r_freq <= {r_f_start, {FRAC_BITS{1'b0}}};
        else if (r_dir_down)
          r_freq <= r_freq - r_f_step;
        else
          r_freq <= r_freq + r_f_step;
      end
      if (w_ramp_end) begin
        r_len_cnt   <= '0;
        r_sweep_cnt <= r_sweep_cnt + CNT_BITS'(1);
        if (r_mode == MODE_TRI) r_dir_down <= ~r_dir_down;
      end else begin
        r_len_cnt <= r_len_cnt + CNT_BITS'(1);
      end
    end
  end

  logic [PHASE_BITS-1:0] w_dither;

`ifdef DDS_CHIRP_DITHER_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_lfsr <= 16'hACE1;
    else if (w_accept) r_lfsr <= 16'hACE1;
    else if (w_run)    r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // LFSR MSB lands just below the LUT address LSB
  assign w_dither = PHASE_BITS'({r_lfsr, {PHASE_BITS{1'b0}}} >> (LUT_BITS + 16));
`else
  assign w_dither = '0;
`endif

  logic [PHASE_BITS-1:0]  w_phase_dith;
  logic [LUT_BITS-1:0]    w_top;
  logic [c_addr_bits-1:0] w_off, w_addr;
  logic                   w_mirror, w_sign, w_peak;

  assign w_phase_dith = r_phase + w_dither;
  assign w_top        = LUT_BITS'(w_phase_dith >> (PHASE_BITS - LUT_BITS));
  assign w_off        = w_top[c_addr_bits-1:0];
  assign w_mirror     = w_top[c_addr_bits];
  assign w_sign       = w_top[c_addr_bits+1];
  assign w_addr       = w_mirror ? (c_addr_bits'(0) - w_off) : w_off;
  // the mirrored quadrant start points at sin(pi/2), one past the table end
  assign w_peak       = w_mirror && (w_off == '0);

  logic [c_addr_bits-1:0] r_addr;
  logic                   r_sign2, r_peak2, r_sign3, r_peak3;
  logic [PIPE_LAT-2:0]    r_v_pipe, r_sync_pipe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr      <= '0;
      r_sign2     <= 1'b0;
      r_peak2     <= 1'b0;
      r_sign3     <= 1'b0;
      r_peak3     <= 1'b0;
      r_v_pipe    <= '0;
      r_sync_pipe <= '0;
    end else begin
      r_addr  <= w_addr;
      r_sign2 <= w_sign;
      r_peak2 <= w_peak;
      r_sign3 <= r_sign2;
      r_peak3 <= r_peak2;
      if (abort) begin
        r_v_pipe    <= '0;
        r_sync_pipe <= '0;
      end else begin
        r_v_pipe    <= {r_v_pipe[PIPE_LAT-3:0], w_run};
        r_sync_pipe <= {r_sync_pipe[PIPE_LAT-3:0], w_run && (r_len_cnt == '0)};
      end
    end
  end

  logic [c_mag_bits-1:0] w_lut_mag, w_mag;

  dds_sin_lut #(
    .ADDR_BITS (c_addr_bits),
    .MAG_BITS  (c_mag_bits)
  ) u_lut (
    .clk    (clk),
    .rst    (rst),
    .i_addr (r_addr),
    .o_mag  (w_lut_mag)
  );

  assign w_mag      = r_peak3 ? c_full : w_lut_mag;
  assign dac_valid  = r_v_pipe[PIPE_LAT-2];
  assign sweep_sync = r_sync_pipe[PIPE_LAT-2];
  assign dac_data   = !dac_valid ? c_mid :
                      r_sign3    ? (c_mid - {1'b0, w_mag}) : (c_mid + {1'b0, w_mag});

endmodule

`default_nettype wire

// File: tb/tb_dds_chirp_gen.sv
// +----------------------------------------------------------------------+
// | tb_dds_chirp_gen: table-driven runs with a sample scoreboard          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_dds_chirp_gen;

  localparam logic [11:0] MID = 12'h800;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] f_start = '0;
  logic [63:0] f_step = '0;
  logic [15:0] sweep_len = '0;
  logic [15:0] n_sweeps = '0;
  logic        busy, done, sweep_sync, dac_valid;
  logic [11:0] dac_data;

  dds_chirp_gen dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .f_start    (f_start),
    .f_step     (f_step),
    .sweep_len  (sweep_len),
    .n_sweeps   (n_sweeps),
    .busy       (busy),
    .done       (done),
    .sweep_sync (sweep_sync),
    .dac_valid  (dac_valid),
    .dac_data   (dac_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] f_start;
    logic [63:0] f_step;
    logic [15:0] len;
    logic [15:0] nsw;
    int          abort_at;
    int          rst_at;
    bit          poke;
    int          exp_samples;
    int          exp_done;
  } vec_t;

  typedef struct {
    int data;
    int tol;
    bit sync;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_pop = 0;
  int   n_done = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] ph);
    exp_t        e;
    logic [9:0]  top;
    real         v;
    top    = ph[31:22];
    v      = 2047.0 * $sin(6.283185307179586 * real'(top) / 1024.0);
    e.data = 2048 + ((v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v));
    e.tol  = (top[7:0] == 8'd0) ? 0 : 1;
    e.sync = 1'b0;
    e.cyc  = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int   diff;
    if (done) n_done++;
    if (rst && dac_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_sample: got data %0d sync %0b, no sample expected", dac_data, sweep_sync);
      end else begin
        e = exp_q.pop_front();
        n_pop++;
        diff = int'(dac_data) - e.data;
        if ($isunknown(dac_data) || diff > e.tol || diff < -e.tol ||
            sweep_sync !== e.sync || cyc != e.cyc) begin
          n_err++;
          $display("FAIL sample: got data %0d sync %0b cycle %0d, expected data %0d(+-%0d) sync %0b cycle %0d",
                   dac_data, sweep_sync, cyc, e.data, e.tol, e.sync, e.cyc);
        end
      end
    end else if (rst) begin
      n_vec++;
      if (dac_data !== MID || sweep_sync !== 1'b0) begin
        n_err++;
        $display("FAIL idle_output: got data %0h sync %0b, expected %0h sync 0", dac_data, sweep_sync, MID);
      end
    end
  end

  task automatic do_run(input vec_t v);
    logic [31:0] m_ph;
    logic [63:0] m_fr;
    bit          m_dir, ramp_end, stopped;
    logic [15:0] m_len, lenlast;
    int          total, pops0, done0;
    exp_t        e;
    pops0   = n_pop;
    done0   = n_done;
    stopped = 1'b0;
    lenlast = (v.len == 16'd0) ? 16'd0 : v.len - 16'd1;
    total   = (v.nsw == 16'd0) ? 1000 : (int'(lenlast) + 1) * int'(v.nsw);
    m_ph    = '0;
    m_fr    = {v.f_start, 32'h0};
    m_dir   = (v.mode == 2'b01);
    m_len   = '0;

    @(negedge clk);
    mode = v.mode; f_start = v.f_start; f_step = v.f_step;
    sweep_len = v.len; n_sweeps = v.nsw; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // scramble inputs: they must have been latched at accept
    mode = 2'($urandom); f_start = $urandom; f_step = {$urandom, $urandom};
    sweep_len = 16'($urandom); n_sweeps = 16'($urandom);
    chk("busy_after_start", busy, 1'b1);

    for (int k = 1; k <= total; k++) begin
      if (k == v.abort_at) begin
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        exp_q.delete();
        chk("abort_busy", busy, 1'b0);
        chk("abort_valid", dac_valid, 1'b0);
        chk("abort_data", dac_data, MID);
        stopped = 1'b1;
        break;
      end
      if (k == v.rst_at) begin
        #2 rst = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", dac_valid, 1'b0);
        chk("rst_data", dac_data, MID);
        chk("rst_done_sync", {done, sweep_sync}, 2'b00);
        exp_q.delete();
        @(negedge clk) rst = 1'b1;
        stopped = 1'b1;
        break;
      end
      e      = mk(m_ph);
      e.sync = (m_len == 16'd0);
      e.cyc  = cyc + 2;
      exp_q.push_back(e);
      ramp_end = (m_len == lenlast);
      m_ph = m_ph + m_fr[63:32];
      if (v.mode != 2'b11) begin
        if (ramp_end && v.mode != 2'b10) m_fr = {v.f_start, 32'h0};
        else if (m_dir)                  m_fr = m_fr - v.f_step;
        else                             m_fr = m_fr + v.f_step;
      end
      if (ramp_end) begin
        m_len = '0;
        if (v.mode == 2'b10) m_dir = !m_dir;
      end else begin
        m_len = m_len + 16'd1;
      end
      if (v.poke && k == 2) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end

    if (!stopped) begin
      chk("done_pulse", {done, busy}, 2'b11);
      @(posedge clk); #1;
      chk("after_done", {done, busy}, 2'b00);
    end
    for (int i = 0; i < 8; i++) begin
      if (exp_q.size() == 0 && !dac_valid) break;
      @(posedge clk); #1;
    end
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("sample_count", 64'(n_pop - pops0), 64'(v.exp_samples));
    chk("done_count", 64'(n_done - done0), 64'(v.exp_done));
    exp_q.delete();
  endtask

  initial begin
    vec_t tbl[10];
    tbl[0] = '{2'b11, 32'h4000_0000, 64'h0,                    16'd8, 16'd1, 0, 0, 1'b0, 8, 1};
    tbl[1] = '{2'b00, 32'h0,         64'h1_0000_0000,          16'd4, 16'd2, 0, 0, 1'b0, 8, 1};
    tbl[2] = '{2'b10, 32'd10,        64'h2_0000_0000,          16'd3, 16'd3, 0, 0, 1'b0, 9, 1};
    tbl[3] = '{2'b01, 32'd1,         64'h2_0000_0000,          16'd4, 16'd1, 0, 0, 1'b0, 4, 1};
    tbl[4] = '{2'b00, 32'h0100_0000, 64'h0080_0000_0000_0000,  16'd5, 16'd2, 0, 0, 1'b1, 10, 1};
    tbl[5] = '{2'b10, 32'h0400_0000, 64'h0100_0000_8000_0000,  16'd4, 16'd2, 0, 0, 1'b0, 8, 1};
    tbl[6] = '{2'b01, 32'h2000_0000, 64'h0300_0000_0000_0000,  16'd0, 16'd3, 0, 0, 1'b0, 3, 1};
    tbl[7] = '{2'b11, 32'h4000_0000, 64'h0,                    16'd8, 16'd0, 5, 0, 1'b0, 3, 0};
    tbl[8] = '{2'b11, 32'h4000_0000, 64'h0,                    16'd8, 16'd0, 0, 6, 1'b0, 3, 0};
    tbl[9] = '{2'b00, 32'h0800_0000, 64'h0,                    16'd2, 16'd1, 0, 0, 1'b0, 2, 1};

    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_sync", sweep_sync, 1'b0);
    chk("reset_valid", dac_valid, 1'b0);
    chk("reset_data", dac_data, MID);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) do_run(tbl[i]);

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
